// File: rtl/serial_pixel_assembler_if.sv
// Byte-in / pixel-out signal bundle for the serial pixel assembler.
// master: the assembler (consumes UART bytes, drives frame-buffer writes).
// slave:  the surrounding logic (feeds bytes, receives writes).
interface serial_pixel_assembler_if #(
  parameter int ADDR_W = 15
);
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              frame_start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              frame_done;
  logic              sync_err;

  modport master (
    input  rx_data, rx_ready, frame_start,
    output wr_en, wr_addr, wr_data, frame_done, sync_err
  );

  modport slave (
    output rx_data, rx_ready, frame_start,
    input  wr_en, wr_addr, wr_data, frame_done, sync_err
  );
endinterface

// File: rtl/serial_pixel_assembler.sv
// Groups UART bytes R,G,B into 24-bit pixels and writes them to a linear
// frame-buffer address that wraps once per frame. A partial pixel is dropped
// (with sync_err) if the next byte does not arrive within TIMEOUT cycles,
// and frame_start realigns both byte phase and address.
module serial_pixel_assembler #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_pixel_assembler_if.master  bus
);
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int TO_W   = $clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  // The expiry is detected one count early so that sync_err lands in the
  // same cycle the counter would have reached TIMEOUT-1.
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {WAIT_R, WAIT_G, WAIT_B} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        r_reg, r_next;
  logic [7:0]        g_reg, g_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [TO_W-1:0]   to_reg, to_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [23:0]       wr_data_reg, wr_data_next;
  logic              frame_done_reg, frame_done_next;
  logic              sync_err_reg, sync_err_next;

  // State, byte, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= WAIT_R;
      r_reg          <= '0;
      g_reg          <= '0;
      addr_reg       <= '0;
      to_reg         <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      r_reg          <= r_next;
      g_reg          <= g_next;
      addr_reg       <= addr_next;
      to_reg         <= to_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      frame_done_reg <= frame_done_next;
      sync_err_reg   <= sync_err_next;
    end
  end

  // Byte-phase FSM, timeout supervision and pixel write generation.
  always_comb begin
    state_next      = state_reg;
    r_next          = r_reg;
    g_next          = g_reg;
    addr_next       = addr_reg;
    to_next         = to_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    frame_done_next = 1'b0;
    sync_err_next   = 1'b0;

    if (bus.frame_start) begin
      // Realign silently; a coincident byte becomes R of pixel 0.
      state_next = WAIT_R;
      addr_next  = '0;
      to_next    = '0;
      if (bus.rx_ready) begin
        r_next     = bus.rx_data;
        state_next = WAIT_G;
      end
    end else begin
      case (state_reg)
        WAIT_R: begin
          to_next = '0;
          if (bus.rx_ready) begin
            r_next     = bus.rx_data;
            state_next = WAIT_G;
          end
        end
        WAIT_G: begin
          if (bus.rx_ready) begin
            g_next     = bus.rx_data;
            to_next    = '0;
            state_next = WAIT_B;
          end else if (to_reg == TO_LAST) begin
            to_next       = '0;
            sync_err_next = 1'b1;
            state_next    = WAIT_R;
          end else begin
            to_next = to_reg + 1'b1;
          end
        end
        WAIT_B: begin
          if (bus.rx_ready) begin
            wr_en_next      = 1'b1;
            wr_addr_next    = addr_reg;
            wr_data_next    = {bus.rx_data, g_reg, r_reg};
            frame_done_next = (addr_reg == LAST_ADDR);
            addr_next       = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
            to_next         = '0;
            state_next      = WAIT_R;
          end else if (to_reg == TO_LAST) begin
            to_next       = '0;
            sync_err_next = 1'b1;
            state_next    = WAIT_R;
          end else begin
            to_next = to_reg + 1'b1;
          end
        end
        default: begin
          state_next = WAIT_R;
          to_next    = '0;
        end
      endcase
    end
  end

  assign bus.wr_en      = wr_en_reg;
  assign bus.wr_addr    = wr_addr_reg;
  assign bus.wr_data    = wr_data_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.sync_err   = sync_err_reg;
endmodule

// File: tb/tb_serial_pixel_assembler.sv
// Directed bench for serial_pixel_assembler on a 4x2 frame with a
// 20-cycle byte timeout.
module tb_serial_pixel_assembler;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 4;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_pixel_assembler_if #(.ADDR_W(AW)) bus ();

  serial_pixel_assembler #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle strobe; returns on the negedge just after it was sampled.
  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    bus.rx_data  = d;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  // Called right after the B strobe was sampled: the write is visible now.
  task automatic check_write(input string tag, input logic [AW-1:0] addr,
                             input logic [23:0] data, input logic done);
    check({tag, ".wr_en"}, 32'(bus.wr_en), 32'd1);
    check({tag, ".addr"}, 32'(bus.wr_addr), 32'(addr));
    check({tag, ".data"}, 32'(bus.wr_data), 32'(data));
    check({tag, ".done"}, 32'(bus.frame_done), 32'(done));
    check({tag, ".serr"}, 32'(bus.sync_err), 32'd0);
    @(negedge clk);
    check({tag, ".wr_en_off"}, 32'(bus.wr_en), 32'd0);
    check({tag, ".hold"}, 32'(bus.wr_data), 32'(data));
  endtask

  task automatic send_pixel(input string tag, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input int gap,
                            input logic [AW-1:0] addr, input logic done);
    send_byte(r);
    idle(gap);
    send_byte(g);
    idle(gap);
    send_byte(b);
    check_write(tag, addr, {b, g, r}, done);
  endtask

  initial begin
    int first_err;
    int err_pulses;
    int saw_wr;

    bus.rx_data     = 8'h00;
    bus.rx_ready    = 1'b0;
    bus.frame_start = 1'b0;

    // Reset state.
    idle(3);
    check("rst.wr_en", 32'(bus.wr_en), 32'd0);
    check("rst.addr", 32'(bus.wr_addr), 32'd0);
    check("rst.data", 32'(bus.wr_data), 32'd0);
    check("rst.done", 32'(bus.frame_done), 32'd0);
    check("rst.serr", 32'(bus.sync_err), 32'd0);
    rst = 1'b1;
    idle(2);

    // Slow bytes with 10-cycle gaps.
    send_pixel("gap", 8'h11, 8'h22, 8'h33, 10, 4'd0, 1'b0);

    // Three strobes on consecutive cycles; write follows in the next cycle.
    @(negedge clk);
    bus.rx_data = 8'hAA; bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_data = 8'hBB;
    check("b2b.no_wr1", 32'(bus.wr_en), 32'd0);
    @(negedge clk);
    bus.rx_data = 8'hCC;
    check("b2b.no_wr2", 32'(bus.wr_en), 32'd0);
    @(negedge clk);
    bus.rx_ready = 1'b0;
    check_write("b2b", 4'd1, 24'hCCBBAA, 1'b0);

    // Rest of the frame: addresses 2..7, then wrap to 0 (mod 8, not mod 16).
    for (int i = 2; i <= 8; i++) begin
      send_pixel($sformatf("frame%0d", i), 8'(i), 8'(i + 16), 8'(i + 32), 0,
                 AW'(i % (W * H)), (i == W * H - 1));
    end

    // Timeout after R,G: sync_err 19 cycles after the G strobe, no write.
    send_byte(8'h01);
    send_byte(8'h02);
    first_err  = 0;
    err_pulses = 0;
    saw_wr     = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (bus.sync_err) begin
        err_pulses++;
        if (first_err == 0) first_err = k;
      end
      if (bus.wr_en) saw_wr = 1;
    end
    check("to.delay", 32'(first_err), 32'd19);
    check("to.pulses", 32'(err_pulses), 32'd1);
    check("to.no_wr", 32'(saw_wr), 32'd0);
    send_pixel("to.next", 8'h04, 8'h05, 8'h06, 0, 4'd1, 1'b0);

    // Advance to address 5, leave R,G pending, then frame_start with a byte.
    send_pixel("pre3", 8'h21, 8'h22, 8'h23, 0, 4'd2, 1'b0);
    send_pixel("pre4", 8'h31, 8'h32, 8'h33, 0, 4'd3, 1'b0);
    send_pixel("pre5", 8'h41, 8'h42, 8'h43, 0, 4'd4, 1'b0);
    send_byte(8'h55);
    send_byte(8'h66);
    @(negedge clk);
    bus.rx_data = 8'h77; bus.rx_ready = 1'b1; bus.frame_start = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0; bus.frame_start = 1'b0;
    check("fs.serr", 32'(bus.sync_err), 32'd0);
    check("fs.no_wr", 32'(bus.wr_en), 32'd0);
    send_byte(8'h88);
    send_byte(8'h99);
    check_write("fs", 4'd0, 24'h998877, 1'b0);

    // Async reset mid-pixel: outputs clear before the next clock edge.
    send_pixel("pre_rst", 8'h01, 8'h02, 8'h03, 0, 4'd1, 1'b0);
    send_byte(8'hE1);
    send_byte(8'hE2);
    #2 rst = 1'b0;
    #1;
    check("arst.addr", 32'(bus.wr_addr), 32'd0);
    check("arst.data", 32'(bus.wr_data), 32'd0);
    check("arst.wr_en", 32'(bus.wr_en), 32'd0);
    idle(2);
    rst = 1'b1;
    send_pixel("post_rst", 8'hD1, 8'hD2, 8'hD3, 0, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Whole-run watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_pixel_assembler.md
Name: serial_pixel_assembler

Overview:
- Producer side of the 24-bit pixel interface consumed by the dithering stage.
- Takes the byte stream from the UART receiver and groups each three consecutive bytes (R, G, B) into one 24-bit pixel.
- Writes each pixel into the frame buffer at a linear address that auto-increments and wraps once per frame.
- Resynchronises after inter-byte gaps and on an explicit frame-start command.

Parameters:
- WIDTH, 160, pixels per line.
- HEIGHT, 120, lines per frame.
- ADDR_W, 15, frame-buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- TIMEOUT, 50000, clk cycles allowed between bytes of one pixel before the partial pixel is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_ready  in  1  one-cycle strobe: rx_data valid this cycle
- frame_start  in  1  one-cycle strobe: restart at address 0, byte phase R
- wr_en  out  1  one-cycle frame-buffer write strobe
- wr_addr  out  ADDR_W  write address, valid while wr_en=1
- wr_data  out  24  pixel: [7:0]=R, [15:8]=G, [23:16]=B
- frame_done  out  1  one-cycle pulse, coincident with the wr_en of the last pixel (address WIDTH*HEIGHT-1)
- sync_err  out  1  one-cycle pulse when a partial pixel is dropped by timeout

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state WAIT_R, address counter 0, timeout counter 0, byte registers 0.
- States:
  - WAIT_R: on rx_ready, capture rx_data as R and go to WAIT_G.
  - WAIT_G: on rx_ready, capture G and go to WAIT_B.
  - WAIT_B: on rx_ready, capture B and return to WAIT_R.
- Write timing: in the cycle after the B strobe:
  - wr_en=1 for exactly one cycle.
  - wr_data={B,G,R}.
  - wr_addr = current address counter.
  - The counter then increments.
- Write latency: 1 cycle from the B strobe to wr_en.
- Wrap: when the written address equals WIDTH*HEIGHT-1, frame_done=1 in the same cycle as wr_en, and the counter returns to 0. Counting is modulo WIDTH*HEIGHT, never 2^ADDR_W.
- Timeout:
  - The counter clears on every rx_ready.
  - It increments each cycle while in WAIT_G or WAIT_B and is held at 0 in WAIT_R.
  - On reaching TIMEOUT-1 without a byte: state goes to WAIT_R, partial bytes are discarded, sync_err pulses for one cycle, and the address is not advanced.
- rx_ready on the same cycle the timeout expires: the byte wins; it is captured normally and there is no sync_err.
- frame_start:
  - Synchronous; highest priority after reset.
  - Forces state WAIT_R, address 0 and timeout counter 0, and drops any partial pixel without a sync_err.
  - If rx_ready is coincident, that byte is captured as R of pixel 0 (next state WAIT_G).
  - A wr_en already scheduled for the current cycle still completes, using the old address.
- wr_en and frame_done are never asserted together with sync_err.
- Back-to-back bytes on consecutive cycles are legal. Three strobes on consecutive cycles yield a write one cycle after the third.
- Outputs are registered and there are no combinational paths from inputs to outputs.
- wr_data and wr_addr hold their last values when wr_en=0.

Test Plan:
- Reset, then bytes 0x11, 0x22, 0x33 with 10-cycle gaps -> one wr_en, wr_addr=0, wr_data=0x332211. Next pixel goes to wr_addr=1.
- Strobes on 3 consecutive cycles (0xAA, 0xBB, 0xCC) -> wr_en on cycle 4, wr_data=0xCCBBAA.
- Full frame: WIDTH=4, HEIGHT=2, 8 pixels -> addresses 0..7; frame_done only with address 7. The 9th pixel goes to address 0.
- TIMEOUT=20: send 0x01, 0x02, then idle 25 cycles -> sync_err pulse 19 cycles after the 0x02 strobe, no wr_en. Next 3 bytes 0x04, 0x05, 0x06 -> wr_data=0x060504 at the unchanged address.
- frame_start at address 5 with G captured, coincident with rx_ready=0x77 -> no sync_err. Then bytes 0x88, 0x99 -> wr_addr=0, wr_data=0x998877.
- rst deasserted mid-pixel (after R, G) -> all outputs 0 immediately. After release, 3 new bytes are written to address 0.
